vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 Parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 Parameter V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical porches and sync in lines.
REQ-007 Parameter H_POL / V_POL, default 0 / 0, asserted sync level (0 = active-low).
REQ-008 Parameter XW / YW, default 10 / 10, counter widths; FW, default 8, frame counter width.
REQ-009 clk  input  1  sole clock, rising edge.
REQ-010 reset  input  1  asynchronous, active-low reset.
REQ-011 en  input  1  pixel-tick enable; counters advance only when high.
REQ-012 clr  input  1  synchronous clear to origin (0,0).
REQ-013 x  output  XW  current horizontal position, 0..H_TOTAL-1.
REQ-014 y  output  YW  current vertical position, 0..V_TOTAL-1.
REQ-015 hsync / vsync  output  1 each  sync pulses at H_POL / V_POL asserted level.
REQ-016 active  output  1  high when x < H_ACTIVE and y < V_ACTIVE.
REQ-017 line_end / frame_end  output  1 each  position-aligned end-of-line / end-of-frame flags.
REQ-018 frame_cnt  output  FW  completed-frame count (present only per REQ-034).

Function
REQ-019 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise; elaboration SHALL fail if H_TOTAL > 2^XW or V_TOTAL > 2^YW.
REQ-020 On a cycle with en=1, clr=0: x increments; at x = H_TOTAL-1, x wraps to 0 and y increments.
REQ-021 At x = H_TOTAL-1 and y = V_TOTAL-1 with en=1, both wrap to 0 on the same edge.
REQ-022 en=0 holds x, y, and all flags unchanged.
REQ-023 clr=1 forces x=0, y=0 on the next edge regardless of en; clr has priority over en.
REQ-024 hsync, vsync, active, line_end, frame_end SHALL be registered, computed from next-state counts so each is valid in the same cycle as the x/y it describes (zero-cycle skew vs x/y).
REQ-025 hsync asserted iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC; otherwise ~H_POL.
REQ-026 vsync asserted iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC; otherwise ~V_POL.
REQ-027 line_end high iff x = H_TOTAL-1; frame_end high iff x = H_TOTAL-1 and y = V_TOTAL-1.
REQ-028 Counter arithmetic SHALL never exceed H_TOTAL-1 / V_TOTAL-1; no out-of-range values reachable.

Reset
REQ-029 reset low asynchronously forces x=0, y=0, active=1, hsync=~H_POL, vsync=~V_POL, line_end=0, frame_end=0, frame_cnt=0.
REQ-030 Reset asserted mid-line or mid-frame SHALL abandon the frame; first en after release advances from (0,0) to (1,0).
REQ-031 Outputs after clr match reset values except frame_cnt, which clr does not modify.

Configuration
REQ-032 Macro VGA_TIMING_FRAME_CNT_EN controls the frame counter.
REQ-033 Defined: frame_cnt increments by 1, modulo 2^FW, on each edge where en=1, clr=0 and frame_end=1.
REQ-034 Undefined: frame_cnt port and its register are absent; all other behaviour identical.

Verification
REQ-035 Defaults, reset then en=1 for 800 cycles -> x counts 0..799, line_end high only at x=799, then x=0, y=1.
REQ-036 Defaults, en=1 continuous -> hsync low exactly for x=656..751 (96 cycles), vsync low exactly for y=490..491, active low for x>=640 or y>=480.
REQ-037 Defaults, run to x=799,y=524 -> frame_end=1 that cycle; next edge x=0, y=0, active=1; with macro, frame_cnt 0->1.
REQ-038 en toggled 1/0 alternately -> x advances every other cycle; all flags stable on en=0 cycles.
REQ-039 clr=1 with en=1 at x=300,y=200 -> next cycle x=0,y=0, hsync=1, vsync=1; frame_cnt unchanged; reset pulsed low mid-frame -> immediate reset values.
REQ-040 With macro, FW=2, run 5 frames -> frame_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered sync,
// blanking and end-of-line/frame flags. Optional macro: VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int XW       = 10,
    parameter int YW       = 10,
    parameter int FW       = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          clr,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic          line_end,
    output logic          frame_end
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [FW-1:0] frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Extra top bit lets window limits equal to 2^W be represented.
    localparam logic [XW:0] HA_LIM = (XW+1)'(H_ACTIVE);
    localparam logic [XW:0] HS_LO  = (XW+1)'(H_ACTIVE + H_FP);
    localparam logic [XW:0] HS_HI  = (XW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW:0] VA_LIM = (YW+1)'(V_ACTIVE);
    localparam logic [YW:0] VS_LO  = (YW+1)'(V_ACTIVE + V_FP);
    localparam logic [YW:0] VS_HI  = (YW+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [XW-1:0] X_MAX = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(V_TOTAL - 1);

    if (H_TOTAL > (1 << XW)) begin : g_bad_xw
        $error("vga_timing_gen: H_TOTAL does not fit in XW bits");
    end
    if (V_TOTAL > (1 << YW)) begin : g_bad_yw
        $error("vga_timing_gen: V_TOTAL does not fit in YW bits");
    end
    if (FW < 1) begin : g_bad_fw
        $error("vga_timing_gen: FW must be at least 1");
    end

    logic [XW-1:0] x_n;
    logic [YW-1:0] y_n;
    logic          hs_n;
    logic          vs_n;
    logic          act_n;
    logic          le_n;
    logic          fe_n;

    // Next position: clear wins, then enabled advance with wraps, else hold.
    always_comb begin
        x_n = x;
        y_n = y;
        if (clr) begin
            x_n = '0;
            y_n = '0;
        end else if (en) begin
            if (x == X_MAX) begin
                x_n = '0;
                y_n = (y == Y_MAX) ? '0 : y + 1'b1;
            end else begin
                x_n = x + 1'b1;
            end
        end
    end

    // Flags derived from the next position so they land with their x/y.
    always_comb begin
        hs_n  = ~H_POL;
        vs_n  = ~V_POL;
        act_n = 1'b0;
        le_n  = 1'b0;
        fe_n  = 1'b0;
        if ({1'b0, x_n} >= HS_LO && {1'b0, x_n} < HS_HI) begin
            hs_n = H_POL;
        end
        if ({1'b0, y_n} >= VS_LO && {1'b0, y_n} < VS_HI) begin
            vs_n = V_POL;
        end
        act_n = ({1'b0, x_n} < HA_LIM) && ({1'b0, y_n} < VA_LIM);
        le_n  = (x_n == X_MAX);
        fe_n  = (x_n == X_MAX) && (y_n == Y_MAX);
    end

    // Position and flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x         <= '0;
            y         <= '0;
            hsync     <= ~H_POL;
            vsync     <= ~V_POL;
            active    <= 1'b1;
            line_end  <= 1'b0;
            frame_end <= 1'b0;
        end else begin
            x         <= x_n;
            y         <= y_n;
            hsync     <= hs_n;
            vsync     <= vs_n;
            active    <= act_n;
            line_end  <= le_n;
            frame_end <= fe_n;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Count frames completed by an enabled advance out of the last pixel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt <= '0;
        end else if (en && !clr && frame_end) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end
`endif

endmodule
